// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer for EX.
// Stalls EX for XLEN shift-add / restoring-divide steps, then pulses done.
module ex_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            st_idle, st_run, st_done;
    logic            accept;
    logic            is_div, sgn_a, sgn_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] min_neg;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_r;
    logic [XLEN+1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] step_acc, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;
    logic [XLEN-1:0] fin_res;

    assign st_idle = (state_q == S_IDLE);
    assign st_run  = (state_q == S_RUN);
    assign st_done = (state_q == S_DONE);
    assign accept  = st_idle & req_valid & ~kill;

    assign stall  = accept | st_run;
    assign busy   = st_run | st_done;
    assign done   = st_done & ~kill;
    assign result = res_q;

    assign min_neg = {1'b1, {(XLEN-1){1'b0}}};

    // Request decode: operand signedness and magnitudes
    always_comb begin
        is_div = req_funct3[2];
        sgn_a  = 1'b0;
        sgn_b  = 1'b0;
        unique case (req_funct3)
            3'd1, 3'd4, 3'd6: begin
                sgn_a = req_a[XLEN-1];
                sgn_b = req_b[XLEN-1];
            end
            3'd2:    sgn_a = req_a[XLEN-1];
            default: ;
        endcase
        mag_a = sgn_a ? -req_a : req_a;
        mag_b = sgn_b ? -req_b : req_b;
    end

    // One iteration step plus final sign fix-up and result select
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_r    = {acc_q, lo_q[XLEN-1]};
        div_diff = {1'b0, div_r} - {2'b00, opb_q};
        div_ge   = ~div_diff[XLEN+1];
        if (f3_q[2]) begin
            step_acc = div_ge ? div_diff[XLEN-1:0] : div_r[XLEN-1:0];
            step_lo  = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_acc = mul_sum[XLEN:1];
            step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {step_acc, step_lo};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;
        quo_fix  = (sa_q ^ sb_q) ? -step_lo : step_lo;
        rem_fix  = sa_q ? -step_acc : step_acc;
        unique case (f3_q)
            3'd0:             fin_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fin_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fin_res = quo_fix;
            default:          fin_res = rem_fix;
        endcase
    end

    // Next-state logic: accept, iterate, complete, kill
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d  = req_funct3;
                    sa_d  = sgn_a;
                    sb_d  = sgn_b;
                    acc_d = '0;
                    lo_d  = mag_a;
                    opb_d = mag_b;
                    cnt_d = '0;
                    if (is_div && req_b == '0) begin
                        res_d   = req_funct3[1] ? req_a : '1;
                        state_d = S_DONE;
                    end else if (is_div && !req_funct3[0] &&
                                 req_a == min_neg && req_b == '1) begin
                        res_d   = req_funct3[1] ? '0 : min_neg;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_acc;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        res_d   = fin_res;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Sequencer for an iterative RV32M multiply/divide unit attached to the EX stage.
- Accepts one M-extension operation when EX decodes it and holds the pipeline with a stall while 32 shift-add or restoring-divide iterations run.
- Returns the 32-bit result to EX on a one-cycle done pulse.
- Honours EX flush (kill), so a mispredicted-path operation is abandoned without side effects.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  EX holds an M-extension instruction (opcode 0110011, funct7 0000001)
- req_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_a  in  XLEN  forwarded rs1 value
- req_b  in  XLEN  forwarded rs2 value
- kill  in  1  EX flush; abandon current/pending operation
- stall  out  1  freeze PC/IF/ID/EX registers
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: result valid, EX may advance
- result  out  XLEN  operation result, held stable until the next accept

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst=0, asynchronous): state IDLE, counter 0, all internal registers 0, stall=0, busy=0, done=0, result=0. Reset mid-operation discards all work.
- stall is combinational: (IDLE & req_valid & ~kill) | RUN. It is 0 in DONE, so EX advances on the done cycle.
- Accept: IDLE & req_valid & ~kill at edge T0. Latch funct3, operand signs and magnitudes.
  - Signed operands: DIV/REM/MULH both signed; MULHSU only a signed; others unsigned.
  - Magnitude = two's-complement absolute value. |0x80000000| = 0x80000000 as unsigned.
- Fast path at accept, next state DONE, done in cycle T0+1:
  - b == 0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = req_a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV 0x80000000, REM 0.
- Otherwise next state RUN with counter=0.
  - Multiply: 64-bit product register, shift-add one multiplier bit per cycle.
  - Divide: restoring; remainder/quotient registers, one quotient bit per cycle, MSB first.
- RUN: counter increments each cycle. When counter == XLEN-1, next state DONE. RUN therefore lasts exactly XLEN cycles; done is asserted in cycle T0+XLEN+1 (33 for XLEN=32).
- Sign fix-up is applied when entering DONE:
  - Product is negated if the operand signs differ (signed ops only).
  - Quotient sign = sa^sb; remainder sign = sa.
  - MUL selects product[31:0]; MULH/MULHSU/MULHU select product[63:32].
- DONE: done=1 for exactly one cycle, result registered, next state IDLE. A new req_valid may be accepted in the following IDLE cycle, never in the DONE cycle.
- kill has priority over everything except reset:
  - In RUN or DONE: next state IDLE and done is suppressed. If kill arrives in DONE, done is forced 0 that cycle.
  - In IDLE with req_valid: request not accepted and stall=0.
  - result is left unchanged by kill.
- busy = RUN | DONE.
- req_* are ignored outside IDLE; operands are latched only on accept.
- No X propagation: every register has a reset value.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3): stall high cycles 0..32, done at cycle 33, result 0xFFFFFFEB. Repeat with MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULH a=b=0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. REMU a=100, b=7 -> 2. Each done at cycle 33.
- Corner fast path: DIVU a=5, b=0 -> 0xFFFFFFFF with done at cycle 1. REM a=0x80000000, b=0xFFFFFFFF -> 0 with done at cycle 1.
- Kill paths:
  - Accept DIV, assert kill at cycle 10: no done pulse, busy 0 from cycle 11, stall 0 from cycle 11.
  - Back-to-back MUL accepted at cycle 11 completes at cycle 44.
  - kill coincident with req_valid in IDLE: no accept.
- Drop rst to 0 mid-RUN (asynchronously, between edges): stall/busy/done/result go to 0 immediately. After release, a fresh DIVU 9/3 returns 3 at cycle 33.
